// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the round-robin memory arbiter: FSM state
//                encoding, default bus widths and the latched command record.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

    // One accepted request, captured at the accept edge
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Requester handshake, read response and memory pin bundle
//                between the requesters, the arbiter and the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) ();

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_write;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_rvalid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        mem_read;
    logic                        mem_write;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data_in;
    logic [DATA_W-1:0]           mem_data_out;

    // Arbiter view
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_rvalid, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_data_in
    );

    // Requester/memory side view
    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_rvalid, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_data_in
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_pick
//  Description : Combinational round-robin picker. Searches the valid vector
//                starting one past the previous winner, wrapping modulo NREQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  wire  [NREQ-1:0]  valid,
    input  wire  [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    int               w_idx;
    logic [IDX_W-1:0] w_sel;

    // First valid requester after last_grant wins; earlier hits mask later ones
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        w_idx     = 0;
        w_sel     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = (int'(last_grant) + i) % NREQ;
            w_sel = w_idx[IDX_W-1:0];
            if (!found && valid[w_sel]) begin
                found        = 1'b1;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter/sequencer sharing one synchronous memory
//                between NREQ requesters. One request in flight at a time:
//                IDLE (accept) -> ACCESS (strobe) -> [RDWAIT (return data)].
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input wire          clk,
    input wire          rst,
    mem_arbiter_if.slave bus
);

    import mem_arb_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    mem_cmd_t          r_cmd;
    logic [IDX_W-1:0]  r_last_grant;
    logic [NREQ-1:0]   r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic [NREQ-1:0]   w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_found;
    logic              w_accept;
    logic [NREQ-1:0]   w_ready;
    logic              w_mem_read;
    logic              w_mem_write;

    mem_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid      (bus.req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .found      (w_found)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, accept handshake and memory strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ready      = '0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        case (r_state)
            IDLE: begin
                // Reset dominates a coincident accept, so never offer ready then
                if (w_found && !rst) begin
                    w_ready      = w_grant;
                    w_accept     = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_mem_write  = r_cmd.write;
                w_mem_read   = !r_cmd.write;
                w_state_next = r_cmd.write ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Latch the winning command and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd        <= '0;
            r_last_grant <= IDX_W'(NREQ - 1);
        end else if (w_accept) begin
            r_cmd.write  <= bus.req_write[w_grant_idx];
            r_cmd.addr   <= bus.req_addr[w_grant_idx];
            r_cmd.wdata  <= bus.req_wdata[w_grant_idx];
            r_last_grant <= w_grant_idx;
        end
    end

    // Read response: one-cycle rvalid to the owner, data held until next read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (r_state == RDWAIT) begin
                r_rvalid[r_last_grant] <= 1'b1;
                r_rdata                <= bus.mem_data_out;
            end
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.rsp_rvalid  = r_rvalid;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_addr    = r_cmd.addr;
    assign bus.mem_data_in = r_cmd.wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Bench for mem_arbiter with a transaction-level model of the
//                grant order, strobe timing and read data, plus a memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int NOPS = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous 32-entry memory
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
        if (bus.mem_read)  bus.mem_data_out <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Winner = first valid index after 'last', wrapping modulo NREQ; -1 if none
    function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
        logic [NREQ-1:0] t;
        for (int k = 1; k <= NREQ; k++) begin
            t = v >> ((last + k) % NREQ);
            if (t[0]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [DW-1:0]   sb [32];
    int              m_last = NREQ - 1;
    int              next_free = 0;
    int              acc_cyc = 0;
    bit              acc_pend = 1'b0;
    bit              acc_wr = 1'b0;
    bit              rd_pend = 1'b0;
    int              rd_cyc = 0;
    int              rd_req = 0;
    logic [DW-1:0]   rd_data = '0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [DW-1:0]   m_rdata = '0;
    bit              armed = 1'b0;
    logic [NREQ-1:0] dut_hs = '0;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rv;
    logic            exp_rd;
    logic            exp_wr;
    int              win;

    // Compare DUT outputs against the model every cycle, mid-cycle
    always @(negedge clk) begin
        if (armed) begin
            exp_rd = 1'b0;
            exp_wr = 1'b0;
            exp_rv = '0;
            if (acc_pend && cyc == acc_cyc + 1) begin
                exp_wr = acc_wr;
                exp_rd = !acc_wr;
            end
            if (rd_pend && cyc == rd_cyc) begin
                exp_rv[rd_req] = 1'b1;
                m_rdata = rd_data;
                rd_pend = 1'b0;
            end
            win = -1;
            if (!rst && cyc >= next_free) win = rr_model(bus.req_valid, m_last);
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;

            check("req_ready", bus.req_ready, exp_ready);
            check("mem_read", bus.mem_read, exp_rd);
            check("mem_write", bus.mem_write, exp_wr);
            n_checks++;
            assert (!(bus.mem_read && bus.mem_write)) else begin
                n_err++;
                $display("FAIL mutex: mem_read=%0b mem_write=%0b (cycle %0d)",
                         bus.mem_read, bus.mem_write, cyc);
            end
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_data_in", bus.mem_data_in, m_wdata);
            check("rsp_rvalid", bus.rsp_rvalid, exp_rv);
            check("rsp_rdata", bus.rsp_rdata, m_rdata);

            dut_hs = bus.req_valid & bus.req_ready;

            if (win >= 0) begin
                m_last   = win;
                acc_pend = 1'b1;
                acc_cyc  = cyc;
                acc_wr   = bus.req_write[win];
                m_addr   = bus.req_addr[win];
                m_wdata  = bus.req_wdata[win];
                if (acc_wr) begin
                    sb[m_addr] = m_wdata;
                    next_free  = cyc + 2;
                end else begin
                    rd_pend   = 1'b1;
                    rd_cyc    = cyc + 3;
                    rd_req    = win;
                    rd_data   = sb[m_addr];
                    next_free = cyc + 3;
                end
            end
        end
        if (rst) begin
            m_last    = NREQ - 1;
            next_free = cyc + 1;
            acc_pend  = 1'b0;
            rd_pend   = 1'b0;
            m_addr    = '0;
            m_wdata   = '0;
            m_rdata   = '0;
            dut_hs    = '0;
            armed     = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out, got no handshake expected completion", name);
    endtask

    // Keep ticking until every raised valid has been accepted
    task automatic serve(input int bound);
        int n = 0;
        while (bus.req_valid != '0) begin
            tick();
            for (int i = 0; i < NREQ; i++) if (dut_hs[i]) bus.req_valid[i] = 1'b0;
            n++;
            if (n > bound) begin
                timeout_fail("serve");
                bus.req_valid = '0;
            end
        end
    endtask

    int order[$];
    int hcyc[$];
    int nxt[2];
    int issued;
    int steps;

    initial begin
        for (int a = 0; a < 32; a++) begin
            mem[a] = '0;
            sb[a]  = '0;
        end
        bus.mem_data_out = '0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Single write from requester 0
        tick();
        bus.req_valid[0] = 1'b1;
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 5'd5;
        bus.req_wdata[0] = 8'hA5;
        @(negedge clk);
        check("wr_ready_lit", bus.req_ready, 3'b001);
        tick();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("wr_strobe_lit", bus.mem_write, 1'b1);
        check("wr_addr_lit", bus.mem_addr, 5'd5);
        check("wr_data_lit", bus.mem_data_in, 8'hA5);
        @(negedge clk);
        check("wr_idle_lit", bus.mem_write, 1'b0);

        // Read-back from requester 1
        tick();
        bus.req_valid[1] = 1'b1;
        bus.req_write[1] = 1'b0;
        bus.req_addr[1]  = 5'd5;
        @(negedge clk);
        check("rd_ready_lit", bus.req_ready, 3'b010);
        tick();
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        check("rd_strobe_lit", bus.mem_read, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rd_rvalid_lit", bus.rsp_rvalid, 3'b010);
        check("rd_rdata_lit", bus.rsp_rdata, 8'hA5);

        // Reset during RDWAIT of a read from requester 0
        tick();
        bus.req_valid[0] = 1'b1;
        bus.req_write[0] = 1'b0;
        bus.req_addr[0]  = 5'd5;
        @(negedge clk);
        check("rst_rd_ready_lit", bus.req_ready, 3'b001);
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rvalid_lit", bus.rsp_rvalid, 3'b000);
        check("rst_rdata_lit", bus.rsp_rdata, 8'h00);
        check("rst_addr_lit", bus.mem_addr, 5'd0);
        check("rst_strobes_lit", {bus.mem_read, bus.mem_write}, 2'b00);
        tick();
        bus.req_valid[0] = 1'b1;
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 5'd9;
        bus.req_wdata[0] = 8'h11;
        bus.req_valid[1] = 1'b1;
        bus.req_write[1] = 1'b1;
        bus.req_addr[1]  = 5'd10;
        bus.req_wdata[1] = 8'h22;
        @(negedge clk);
        check("post_rst_first_lit", bus.req_ready, 3'b001);
        serve(50);

        // Contention: requesters 0 and 1 continuously valid, writes to 0..7
        tick();
        for (int i = 0; i < 2; i++) begin
            nxt[i] = 0;
            bus.req_valid[i] = 1'b1;
            bus.req_write[i] = 1'b1;
            bus.req_addr[i]  = AW'(i);
            bus.req_wdata[i] = DW'(8'h40 + i);
        end
        steps = 0;
        while (bus.req_valid != '0 && steps < 100) begin
            tick();
            steps++;
            for (int i = 0; i < 2; i++) begin
                if (dut_hs[i]) begin
                    order.push_back(i);
                    hcyc.push_back(cyc);
                    nxt[i]++;
                    if (nxt[i] < 4) begin
                        bus.req_addr[i]  = AW'(2 * nxt[i] + i);
                        bus.req_wdata[i] = DW'(8'h40 + 2 * nxt[i] + i);
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (steps >= 100) begin
            timeout_fail("contention");
            bus.req_valid = '0;
        end
        check("cont_count", order.size(), 8);
        for (int k = 0; k < order.size(); k++) check("cont_order", order[k], k % 2);
        for (int k = 1; k < hcyc.size(); k++) check("cont_spacing", hcyc[k] - hcyc[k-1], 2);

        // Random sweep of reads/writes with occasional withdrawn requests
        issued = 0;
        steps  = 0;
        while ((issued < NOPS || bus.req_valid != '0) && steps < 20000) begin
            tick();
            steps++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i]) begin
                    if (dut_hs[i]) bus.req_valid[i] = 1'b0;
                    else if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
                end else if (issued < NOPS && $urandom_range(0, 1) == 0) begin
                    bus.req_write[i] = 1'($urandom_range(0, 1));
                    bus.req_addr[i]  = AW'($urandom_range(0, 31));
                    bus.req_wdata[i] = DW'($urandom_range(0, 255));
                    bus.req_valid[i] = 1'b1;
                    issued++;
                end
            end
        end
        if (steps >= 20000) begin
            timeout_fail("sweep");
            bus.req_valid = '0;
        end
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the synchronous 8x32 memory between NREQ requesters.
- Accepts one request at a time over a valid/ready handshake and drives the memory's read/write/addr/data_in pins. Read and write are never driven high together.
- Returns read data to the winning requester with a one-cycle rvalid pulse.
- Sits between the requester blocks and the memory bus in the testbench top.

Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, memory data width

Ports:
- clk  input  1  rising-edge clock, shared with memory
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_write  input  NREQ  1 = write, 0 = read (per requester)
- req_addr  input  NREQ x ADDR_W  per-requester address
- req_wdata  input  NREQ x DATA_W  per-requester write data
- req_ready  output  NREQ  one-hot accept; handshake occurs when valid & ready
- rsp_rvalid  output  NREQ  one-hot read-data-valid pulse
- rsp_rdata  output  DATA_W  read data, qualified by rsp_rvalid
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address
- mem_data_in  output  DATA_W  memory write data
- mem_data_out  input  DATA_W  memory registered read data

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FSM to IDLE.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_data_in, rsp_rvalid, rsp_rdata, req_ready.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has first priority.
  - Any in-flight operation is dropped and no rvalid is issued for it.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If any req_valid, winner g = first valid index searching from last_grant+1 modulo NREQ.
  - req_ready[g]=1 (combinational from state and req_valid); all other ready bits 0.
  - At the posedge, register req_write[g]/addr/wdata into the command registers, set last_grant=g, go to ACCESS.
  - No valid: stay in IDLE, ready all 0.
- ACCESS (exactly one cycle):
  - mem_write=1 or mem_read=1 per the latched op; mem_addr and mem_data_in come from the command registers.
  - Write: next state IDLE.
  - Read: next state RDWAIT.
- RDWAIT (one cycle):
  - mem_data_out holds memory[addr], registered by the memory at the end of ACCESS.
  - At the posedge: rsp_rdata <= mem_data_out, rsp_rvalid[g] <= 1, go to IDLE.
  - rsp_rvalid is high for exactly one cycle.
  - rsp_rdata holds its value until the next read completes.
- Latency, with the accept edge at end of cycle T:
  - Strobe is high in T+1.
  - Read rsp_rvalid is high in T+3.
  - Next accept is possible in T+2 (write) or T+3 (read).
  - rsp_rvalid may overlap a new accept in IDLE.
- mem_read and mem_write are low in IDLE and RDWAIT. They are mutually exclusive at all times.
- mem_addr and mem_data_in hold their last values outside ACCESS.
- Requester rules: hold valid and fields stable until accepted. If valid drops before acceptance, no operation occurs.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Address and data are passed through unmodified. No wrap or overflow arithmetic beyond the modulo-NREQ pointer increment.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} arb_state_t
  - localparams ADDR_W=5, DATA_W=8
  - typedef struct packed {logic write; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} mem_cmd_t
- Sub-module mem_rr_pick: purely combinational. Inputs are the valid vector and last_grant; outputs are the one-hot grant and its index. Instantiated once.

Test Plan:
- Reset mid-read (rst asserted during RDWAIT) -> next cycle all outputs 0; no rsp_rvalid ever for the dropped read; after release, req0 wins first.
- Single write: req0 write addr=5 data=8'hA5 -> ready[0] for 1 cycle; mem_write=1, mem_addr=5, mem_data_in=A5 the next cycle; back in IDLE after.
- Read-back: req1 read addr=5 after the write -> mem_read=1 one cycle after accept; rsp_rvalid[1]=1 with rsp_rdata=8'hA5 two cycles later; rsp_rvalid[0] stays 0.
- Contention: req0 and req1 valid continuously with writes to addr 0..7 -> grants alternate 0,1,0,1; each op is 2 cycles; mem_read is never 1.
- Mutual exclusion plus sweep: random mix of 200 reads/writes over addr 0..31 -> assertion that mem_read & mem_write is never 1; every read returns the scoreboard value; no rvalid is issued without a prior read accept.
